cmp_rom_arbiter: RTL and testbench

- Shares one lookup-table 2-bit magnitude comparator between NREQ requesters.
- Accepts one request at a time over a per-requester valid/ready handshake. Performs a registered table read and returns {lt, gt, eq} tagged with the requester ID over a single response handshake.
- Sits between the lab datapath clients and the compare table, replacing per-client comparator copies.

---
 rtl/cmp_rom_arbiter.sv | 145 ++++++++++++++
 tb/tb_cmp_rom_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_rom_arbiter.sv
// Arbitrated front end for one shared 2-bit magnitude-compare lookup table.
// Define CMP_ROUND_ROBIN_EN for round-robin grants; otherwise the lowest index wins.
module cmp_rom_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_a,
    input  logic [2*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_lt,
    output logic              rsp_gt,
    output logic              rsp_eq,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       addr_reg;
    logic [IDW-1:0]   id_reg;
    logic [2:0]       table_rom [16];
    logic [2:0]       rom_data;
    logic             rom_onehot;
    logic             any_valid;
    logic [IDW-1:0]   win;

    // Table word {lt,gt,eq} for address {b,a}, built entirely at elaboration.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_table
            localparam int TA = gi % 4;
            localparam int TB = gi / 4;
            assign table_rom[gi] = {(TA < TB), (TA > TB), (TA == TB)};
        end
    endgenerate

    assign rom_data   = table_rom[addr_reg];
    assign rom_onehot = (rom_data == 3'b100) || (rom_data == 3'b010) || (rom_data == 3'b001);

`ifdef CMP_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_reg;

    // Search begins at ptr and wraps; the first valid requester found wins.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        win       = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                win       = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (state_reg == IDLE && any_valid) begin
            if (win == IDW'(NREQ - 1)) begin
                ptr_reg <= '0;
            end else begin
                ptr_reg <= win + 1'b1;
            end
        end
    end
`else
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_valid && req_valid[k]) begin
                any_valid = 1'b1;
                win       = IDW'(k);
            end
        end
    end
`endif

    // Grant only the winner, only in IDLE, and never while reset is held.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_reg == IDLE) && any_valid && (win == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            id_reg    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_lt    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        addr_reg  <= {req_b[2*int'(win) +: 2], req_a[2*int'(win) +: 2]};
                        id_reg    <= win;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    {rsp_lt, rsp_gt, rsp_eq} <= rom_data;
                    rsp_id    <= id_reg;
                    rsp_valid <= 1'b1;
                    if (!rom_onehot) begin
                        err <= 1'b1;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    // Completing the handshake always passes through IDLE before the next accept.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_rom_arbiter.sv
// Randomised and directed bench for cmp_rom_arbiter against a transaction-level model.
module tb_cmp_rom_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [2*NREQ-1:0] req_a = '0;
    logic [2*NREQ-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_lt, rsp_gt, rsp_eq, err;

    cmp_rom_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    // Model: one outstanding transaction, its age in cycles since the accept edge.
    bit m_busy = 0;
    int m_age = 0;
    int m_id = 0, m_a = 0, m_b = 0;
    int m_ptr = 0;
    int grant_q[$];
    int acc_q[$];

    int last_id, last_lt, last_gt, last_eq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
`ifdef CMP_ROUND_ROBIN_EN
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Compare process: outputs sampled on the falling edge, model advanced for the next rising edge.
    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] exp_ready;
        bit exp_valid;
        cycle++;
        if (!rst_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_data", {rsp_lt, rsp_gt, rsp_eq}, 0);
            check("rst_err", err, 0);
            m_busy = 0;
            m_ptr = 0;
        end else begin
            exp_ready = '0;
            w = -1;
            if (!m_busy) begin
                w = pick(req_valid);
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            exp_valid = m_busy && (m_age >= 2);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_valid);
            check("err", err, 0);
            if (exp_valid) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_lt", rsp_lt, m_a < m_b);
                check("rsp_gt", rsp_gt, m_a > m_b);
                check("rsp_eq", rsp_eq, m_a == m_b);
            end
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1;
                    m_age = 1;
                    m_id = w;
                    m_a = int'(req_a[2*w +: 2]);
                    m_b = int'(req_b[2*w +: 2]);
                    m_ptr = (w + 1) % NREQ;
                    grant_q.push_back(w);
                    acc_q.push_back(cycle);
                end
            end else if (exp_valid && rsp_ready) begin
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
    end

    // Issue one request with rsp_ready high; report granted id and accept-to-response latency.
    task automatic do_req(input logic [NREQ-1:0] mask, output int gid, output int lat);
        gid = -1;
        lat = -1;
        rsp_ready = 1'b1;
        req_valid = mask;
        for (int k = 0; k < 20 && gid < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) gid = i;
            end
        end
        check("accept_seen", gid >= 0, 1);
        @(posedge clk);
        #1 req_valid = '0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) lat = n;
        end
        check("response_seen", lat >= 0, 1);
        last_id = int'(rsp_id);
        last_lt = int'(rsp_lt);
        last_gt = int'(rsp_gt);
        last_eq = int'(rsp_eq);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int gid, lat, cnt;
        int rr_exp[5];
        logic [2:0] held;
        logic [IDW-1:0] held_id;
`ifdef CMP_ROUND_ROBIN_EN
        rr_exp = '{0, 1, 2, 3, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0};
`endif
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;

        // Exhaustive compare from requester 0.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                req_a = NREQ*2'($urandom);
                req_b = NREQ*2'($urandom);
                req_a[1:0] = 2'(a);
                req_b[1:0] = 2'(b);
                do_req(4'b0001, gid, lat);
                $display("sweep a=%0d b=%0d id=%0d lat=%0d lt=%0d gt=%0d eq=%0d", a, b, gid, lat, last_lt, last_gt, last_eq);
                check("sweep_grant", gid, 0);
                check("sweep_latency", lat, 2);
                check("sweep_rsp_id", last_id, 0);
                if (a == 2 && b == 1) check("pin_2_vs_1", {last_lt[0], last_gt[0], last_eq[0]}, 3'b010);
                if (a == 1 && b == 3) check("pin_1_vs_3_lt", last_lt, 1);
                if (a == b) check("pin_equal_eq", last_eq, 1);
            end
        end

        // All requesters continuously valid from a fresh reset.
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 grant_q.delete();
        acc_q.delete();
        rst_n = 1'b1;
        repeat (17) @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        cnt = grant_q.size();
        $display("continuous grants=%0d first=%p", cnt, grant_q);
        check("cont_grant_count", cnt >= 5, 1);
        for (int k = 0; k < 5 && k < cnt; k++) check("cont_grant_order", grant_q[k], rr_exp[k]);
        for (int k = 1; k < 5 && k < cnt; k++) check("cont_accept_spacing", acc_q[k] - acc_q[k-1], 3);

        // Back-pressure held for 5 cycles in RESP.
        rsp_ready = 1'b0;
        req_a = 8'($urandom);
        req_b = 8'($urandom);
        req_valid = 4'b0100;
        gid = -1;
        for (int k = 0; k < 20 && gid < 0; k++) begin
            @(negedge clk);
            if (req_ready[2]) gid = 2;
        end
        check("bp_accept", gid, 2);
        @(posedge clk);
        #1 req_valid = '1;
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) lat = n;
        end
        check("bp_response_seen", lat, 2);
        held = {rsp_lt, rsp_gt, rsp_eq};
        held_id = rsp_id;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_valid_held", rsp_valid, 1);
            check("bp_data_held", {rsp_lt, rsp_gt, rsp_eq}, held);
            check("bp_id_held", rsp_id, held_id);
            check("bp_req_ready_zero", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_before_hs", rsp_valid, 1);
        @(negedge clk);
        check("bp_valid_after_hs", rsp_valid, 0);
        $display("backpressure id=%0d data=%b", held_id, held);
        @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(posedge clk);
        #1;

        // Reset while the request is in READ.
        req_valid = 4'b0010;
        gid = -1;
        for (int k = 0; k < 20 && gid < 0; k++) begin
            @(negedge clk);
            if (req_ready[1]) gid = 1;
        end
        check("rst_mid_accept", gid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = '1;
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_mid_no_response", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        do_req(4'b1111, gid, lat);
        $display("after reset grant=%0d", gid);
        check("rst_ptr_zero", gid, 0);

        // Wrap-around: drive ptr to 3, then only requester 1 is valid.
        do_req(4'b0100, gid, lat);
        check("wrap_setup", gid, 2);
        do_req(4'b0010, gid, lat);
        $display("wrap grant=%0d", gid);
        check("wrap_grant", gid, 1);
        do_req(4'b1111, gid, lat);
        $display("wrap next grant=%0d", gid);
`ifdef CMP_ROUND_ROBIN_EN
        check("wrap_ptr_after", gid, 2);
`else
        check("wrap_ptr_after", gid, 0);
`endif

        // Random traffic including dropped requests, back-pressure and one reset.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            req_valid = NREQ'($urandom);
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (i == 200) rst_n = 1'b0;
            if (i == 202) rst_n = 1'b1;
        end
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("random phase done, total grants logged=%0d", grant_q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
